// File: rtl/led_pkg.sv
// Shared constants and types for the LED rate scheduler.
// Optional requester-0 preemption is enabled in led_rate_scheduler by LED_SCHED_PREEMPT_EN.
package led_pkg;

    localparam int unsigned N_REQ = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 32;

    // Blinker rate codes as seen on o_select1/o_select0
    localparam logic [1:0] RATE_1HZ  = 2'b00;
    localparam logic [1:0] RATE_5HZ  = 2'b01;
    localparam logic [1:0] RATE_10HZ = 2'b10;
    localparam logic [1:0] RATE_20HZ = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SHOW = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] onehot_to_idx(input logic [N_REQ-1:0] oh);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Combinational 4-way round-robin pick: first requester at or above pointer, wrapping.
module rr_arbiter4
    import led_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] pointer,
    output logic [N_REQ-1:0] grant,
    output logic             valid
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = pointer + IDX_W'(i);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_rate_scheduler.sv
// Time-slices one status LED between four requesters with SHOW/GAP dwell timing.
// Define LED_SCHED_PREEMPT_EN to let requester 0 cut short another owner's SHOW.
module led_rate_scheduler
    import led_pkg::*;
#(
    parameter int unsigned c_slot_count = 50_000_000,
    parameter int unsigned c_gap_count  = 5_000_000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic [7:0] i_rate,
    output logic [3:0] o_grant,
    output logic       o_enable,
    output logic       o_select0,
    output logic       o_select1,
    output logic       o_busy
);

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] ptr_q;
    logic [IDX_W-1:0] owner_q;
    logic [1:0]       rate_q;
    logic [N_REQ-1:0] grant_q;
    logic             enable_q;
    logic             busy_q;

    logic [N_REQ-1:0] arb_grant;
    logic             arb_valid;
    logic [IDX_W-1:0] arb_idx;
    logic [1:0]       win_rate;
    logic             slot_end;
    logic             gap_end;
    logic             owner_held;
    logic             preempt;

    rr_arbiter4 u_arb (
        .req     (i_req),
        .pointer (ptr_q),
        .grant   (arb_grant),
        .valid   (arb_valid)
    );

    assign arb_idx    = onehot_to_idx(arb_grant);
    assign win_rate   = i_rate[{arb_idx, 1'b0} +: 2];
    assign slot_end   = (cnt_q == CNT_W'(c_slot_count - 1));
    assign gap_end    = (cnt_q == CNT_W'(c_gap_count - 1));
    assign owner_held = |(i_req & grant_q);

`ifdef LED_SCHED_PREEMPT_EN
    assign preempt = i_req[0] && (owner_q != '0);
`else
    assign preempt = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            ptr_q    <= '0;
            owner_q  <= '0;
            rate_q   <= RATE_1HZ;
            grant_q  <= '0;
            enable_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_GAP: begin
                    if (state_q == ST_IDLE || gap_end) begin
                        cnt_q <= '0;
                        if (arb_valid) begin
                            state_q  <= ST_SHOW;
                            owner_q  <= arb_idx;
                            rate_q   <= win_rate;
                            grant_q  <= arb_grant;
                            enable_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    // Timeout, early release and preemption all leave via GAP
                    if (slot_end || !owner_held || preempt) begin
                        state_q  <= ST_GAP;
                        cnt_q    <= '0;
                        grant_q  <= '0;
                        enable_q <= 1'b0;
                        ptr_q    <= preempt ? '0 : owner_q + IDX_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q  <= ST_IDLE;
                    cnt_q    <= '0;
                    grant_q  <= '0;
                    enable_q <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_grant   = grant_q;
    assign o_enable  = enable_q;
    assign o_select0 = rate_q[0];
    assign o_select1 = rate_q[1];
    assign o_busy    = busy_q;

endmodule

// File: tb/tb_led_rate_scheduler.sv
// Directed bench for led_rate_scheduler with an 8-cycle slot and 2-cycle gap.
module tb_led_rate_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [7:0] rate;
    logic [3:0] grant;
    logic       enable;
    logic       sel0;
    logic       sel1;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    led_rate_scheduler #(
        .c_slot_count (8),
        .c_gap_count  (2)
    ) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_rate    (rate),
        .o_grant   (grant),
        .o_enable  (enable),
        .o_select0 (sel0),
        .o_select1 (sel1),
        .o_busy    (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance one rising edge; outputs are sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [3:0] rr_order [5];

    initial begin
        rr_order[0] = 4'b0001;
        rr_order[1] = 4'b0010;
        rr_order[2] = 4'b0100;
        rr_order[3] = 4'b1000;
        rr_order[4] = 4'b0001;
        req  = '0;
        rate = '0;
        rst  = 1'b1;

        // Reset state
        do_reset();
        check("rst_grant",  32'(grant),  32'h0);
        check("rst_enable", 32'(enable), 32'h0);
        check("rst_busy",   32'(busy),   32'h0);
        check("rst_sel",    32'({sel1, sel0}), 32'h0);
        step();
        check("idle_noreq_grant", 32'(grant), 32'h0);

        // Test 1: single requester, 10 Hz, full slot then gap then re-grant
        req  = 4'b0001;
        rate = 8'b0000_0010;
        step();
        check("t1_grant",  32'(grant),  32'h1);
        check("t1_enable", 32'(enable), 32'h1);
        check("t1_busy",   32'(busy),   32'h1);
        check("t1_sel",    32'({sel1, sel0}), 32'h2);
        for (int i = 1; i < 8; i++) begin
            step();
            check("t1_show_grant", 32'(grant), 32'h1);
        end
        step();
        check("t1_gap_grant",  32'(grant),  32'h0);
        check("t1_gap_enable", 32'(enable), 32'h0);
        check("t1_gap_busy",   32'(busy),   32'h1);
        check("t1_gap_sel",    32'({sel1, sel0}), 32'h2);
        step();
        check("t1_gap2_busy", 32'(busy), 32'h1);
        step();
        check("t1_regrant", 32'(grant), 32'h1);
        req = 4'b0000;
        step();
        check("t1_release_grant", 32'(grant), 32'h0);
        check("t1_release_busy",  32'(busy),  32'h1);
        step();
        step();
        check("t1_idle_busy", 32'(busy), 32'h0);

        // Test 2: all requesting, round-robin order with gaps
        do_reset();
        req  = 4'b1111;
        rate = 8'b11_10_01_00;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t2_grant", 32'(grant), 32'(rr_order[k]));
            check("t2_sel",   32'({sel1, sel0}), 32'(k % 4));
            repeat (7) step();
            step();
            check("t2_gap_grant", 32'(grant), 32'h0);
            step();
            check("t2_gap2_busy", 32'(busy), 32'h1);
        end

        // Tests 3/4: rate change mid-SHOW ignored; early release in SHOW cycle 3
        do_reset();
        req  = 4'b0011;
        rate = 8'b0000_0111;
        step();
        check("t3_grant", 32'(grant), 32'h1);
        check("t3_sel",   32'({sel1, sel0}), 32'h3);
        rate = 8'b0000_0000;
        step();
        check("t4_sel_hold", 32'({sel1, sel0}), 32'h3);
        step();
        check("t3_cyc3_grant", 32'(grant), 32'h1);
        req  = 4'b0010;
        rate = 8'b0000_1000;
        step();
        check("t3_early_gap_grant", 32'(grant), 32'h0);
        check("t3_early_gap_busy",  32'(busy),  32'h1);
        check("t4_gap_sel_hold",    32'({sel1, sel0}), 32'h3);
        step();
        step();
        check("t3_next_grant", 32'(grant), 32'h2);
        check("t4_new_sel",    32'({sel1, sel0}), 32'h2);

        // Test 5: reset in SHOW cycle 4 clears everything, pointer back to 0
        do_reset();
        req  = 4'b0100;
        rate = 8'b0011_0000;
        step();
        check("t5_grant", 32'(grant), 32'h4);
        repeat (3) step();
        rst = 1'b1;
        req = 4'b0101;
        step();
        check("t5_rst_grant",  32'(grant),  32'h0);
        check("t5_rst_enable", 32'(enable), 32'h0);
        check("t5_rst_busy",   32'(busy),   32'h0);
        check("t5_rst_sel",    32'({sel1, sel0}), 32'h0);
        rst = 1'b0;
        step();
        check("t5_post_grant", 32'(grant), 32'h1);

        // Test 6: requester 0 arrives while requester 2 owns the LED
        do_reset();
        req = 4'b0100;
        step();
        check("t6_grant", 32'(grant), 32'h4);
        req = 4'b0101;
`ifdef LED_SCHED_PREEMPT_EN
        step();
        check("t6_preempt_gap", 32'(grant), 32'h0);
        step();
        step();
        check("t6_preempt_grant", 32'(grant), 32'h1);
`else
        for (int i = 1; i < 8; i++) begin
            step();
            check("t6_keep_grant", 32'(grant), 32'h4);
        end
        step();
        check("t6_gap_grant", 32'(grant), 32'h0);
        step();
        step();
        check("t6_next_grant", 32'(grant), 32'h1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/led_rate_scheduler.md
LED_RATE_SCHEDULER -- requirements
Module: led_rate_scheduler

Interface
REQ-001 SHALL have parameter c_slot_count, default 50_000_000: SHOW-state dwell in clock cycles (1 s at 50 MHz); legal range 1..2^32-1.
REQ-002 SHALL have parameter c_gap_count, default 5_000_000: LED-off GAP between grants in cycles; legal range 1..2^32-1.
REQ-003 SHALL have port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port i_rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port i_req, input, 4: per-requester level request; held high while requester wants the LED.
REQ-006 SHALL have port i_rate, input, 8: requester k rate code at bits [2k+1:2k]: 00=1 Hz, 01=5 Hz, 10=10 Hz, 11=20 Hz.
REQ-007 SHALL have port o_grant, output, 4: one-hot current owner; all-zero when no owner.
REQ-008 SHALL have port o_enable, output, 1: drives blinker enable.
REQ-009 SHALL have ports o_select0 and o_select1, output, 1 each: blinker rate select = latched rate code bit 0 and bit 1.
REQ-010 SHALL have port o_busy, output, 1: high in SHOW and GAP.

Function
REQ-011 SHALL implement FSM states IDLE, SHOW, GAP; all outputs registered.
REQ-012 IDLE: o_enable=0, o_grant=0; if any i_req bit high at edge N, SHALL enter SHOW with o_grant/o_enable high after edge N (1-cycle latency).
REQ-013 Winner SHALL be chosen round-robin: first requesting index at or after pointer, searching upward modulo 4.
REQ-014 Winner's 2-bit rate code SHALL be latched on grant; i_rate changes during SHOW SHALL NOT affect o_select0/o_select1.
REQ-015 SHOW SHALL last exactly c_slot_count cycles via a 32-bit counter cleared on entry, then enter GAP.
REQ-016 If the owner's i_req drops during SHOW, the next edge SHALL enter GAP (early release).
REQ-017 On leaving SHOW, pointer SHALL become (winner+1) mod 4.
REQ-018 GAP: o_enable=0, o_grant=0, o_busy=1, o_select0/o_select1 hold last latched code; lasts exactly c_gap_count cycles.
REQ-019 At GAP end, any i_req high SHALL enter SHOW directly with a new round-robin winner; otherwise enter IDLE.
REQ-020 Requests arriving during SHOW or GAP SHALL wait; no request is lost while held high.
REQ-021 Requests shorter than one cycle, or dropped before arbitration, SHALL be ignored.

Reset
REQ-022 i_rst high at an edge SHALL force IDLE, counter=0, pointer=0, latched rate=00, o_grant=0, o_enable=0, o_select0=0, o_select1=0, o_busy=0, overriding any other event in the same cycle, including mid-SHOW and mid-GAP.

Configuration
REQ-023 Macro LED_SCHED_PREEMPT_EN, when defined, SHALL cause i_req[0] high during SHOW owned by requester 1..3 to end SHOW at the next edge, enter GAP, and set pointer=0 so requester 0 wins at GAP end.
REQ-024 Without LED_SCHED_PREEMPT_EN, requester 0 SHALL receive no preemption and is served round-robin only.

Structure
REQ-025 Shared package led_pkg SHALL hold rate code constants (RATE_1HZ..RATE_20HZ) and the FSM state type.
REQ-026 Round-robin winner selection SHALL be the combinational sub-module rr_arbiter4: inputs req[3:0] and pointer[1:0]; outputs one-hot grant and valid.

Verification (c_slot_count=8, c_gap_count=2)
REQ-027 Test 1: i_req=0001, i_rate[1:0]=10 at cycle 0. Required: cycle 1 o_grant=0001, o_enable=1, select1/select0=1/0 for 8 cycles; then 2 GAP cycles; then SHOW again.
REQ-028 Test 2: i_req=1111 held. Required: grant order 0001, 0010, 0100, 1000, 0001, with a 2-cycle GAP between each.
REQ-029 Test 3: owner drops i_req in SHOW cycle 3. Required: GAP entered next edge; pointer advances.
REQ-030 Test 4: i_rate changed mid-SHOW. Required: select outputs unchanged until next grant.
REQ-031 Test 5: i_rst pulsed in SHOW cycle 4. Required: all outputs 0 next cycle; next grant goes to requester 0 if it requests.
REQ-032 Test 6 (LED_SCHED_PREEMPT_EN): requester 2 owns LED and i_req[0] rises. Required: GAP next edge, then o_grant=0001; without the macro, requester 2 completes 8 cycles.
